// File: rtl/mmio_uart_tx_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// MMIO_UART_PARITY_EN adds a PARITY state to the serializer encoding.
package mmio_uart_tx_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned DIV_W = 16;

    localparam int unsigned MMIO_UART_TXDATA_OFFSET  = 0;
    localparam int unsigned MMIO_UART_DIVISOR_OFFSET = 4;

    localparam int unsigned STATUS_TX_BUSY    = 0;
    localparam int unsigned STATUS_FIFO_FULL  = 1;
    localparam int unsigned STATUS_FIFO_EMPTY = 2;
    localparam int unsigned STATUS_PENDING    = 3;
    localparam int unsigned STATUS_COUNT_LSB  = 8;
    localparam int unsigned STATUS_COUNT_W    = 8;

    typedef struct packed {
        logic            enable;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] value;
        logic [1:0]      width;
    } mem_write_control_t;

`ifdef MMIO_UART_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;
`endif

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Generic single-clock circular FIFO; pointers carry one extra wrap bit.
// A pop frees the slot for a push in the same cycle when full.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count    = wr_ptr_q - rd_ptr_q;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: store capture, TX FIFO and 8N1 serializer.
// Define MMIO_UART_PARITY_EN for 8E1 framing (even parity bit before stop).
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [XLEN-1:0] MMIO_BASE       = 32'h0003_0000,
    parameter int unsigned     FIFO_DEPTH      = 8,
    parameter int unsigned     DEFAULT_DIVISOR = 434
) (
    input  logic               clock,
    input  logic               reset,
    input  mem_write_control_t memory_mapped_io_control,
    output logic [XLEN-1:0]    memory_mapped_io_r_data,
    output logic               memory_mapped_io_write_complete,
    output logic               uart_tx
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0]  offset;
    logic             strobe, is_tx, is_div, can_push;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]       fifo_wdata, fifo_rdata;
    logic [CW-1:0]    fifo_count;
    logic             load;

    logic             pending_valid_q, pending_valid_d;
    logic [7:0]       pending_byte_q, pending_byte_d;
    logic             wc_q, wc_d;
    logic [DIV_W-1:0] divisor_q, divisor_d;

    uart_state_t      state_q, state_d;
    logic [DIV_W-1:0] baud_q, baud_d;
    logic [DIV_W-1:0] div_lat_q, div_lat_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
`ifdef MMIO_UART_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic unused_ctrl_bits;
    assign unused_ctrl_bits = ^{memory_mapped_io_control.width,
                                memory_mapped_io_control.value[XLEN-1:DIV_W]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Request capture and retire; a new strobe is ignored while a store is parked.
    always_comb begin
        offset          = memory_mapped_io_control.addr - MMIO_BASE;
        strobe          = memory_mapped_io_control.enable && !pending_valid_q;
        is_tx           = strobe && (offset == XLEN'(MMIO_UART_TXDATA_OFFSET));
        is_div          = strobe && (offset == XLEN'(MMIO_UART_DIVISOR_OFFSET));
        can_push        = !fifo_full || fifo_pop;
        fifo_push       = (pending_valid_q || is_tx) && can_push;
        fifo_wdata      = pending_valid_q ? pending_byte_q
                                          : memory_mapped_io_control.value[7:0];
        pending_valid_d = pending_valid_q ? !can_push : (is_tx && !can_push);
        pending_byte_d  = strobe ? memory_mapped_io_control.value[7:0] : pending_byte_q;
        wc_d            = (pending_valid_q && can_push) || (strobe && (!is_tx || can_push));
        divisor_d       = divisor_q;
        if (is_div) begin
            divisor_d = (memory_mapped_io_control.value[DIV_W-1:0] == '0)
                      ? DIV_W'(1) : memory_mapped_io_control.value[DIV_W-1:0];
        end
    end

    // Serializer next state; a load both pops the FIFO and samples the divisor.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        div_lat_d = div_lat_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
`ifdef MMIO_UART_PARITY_EN
        parity_d  = parity_q;
`endif
        load      = 1'b0;

        case (state_q)
            IDLE: begin
                load = !fifo_empty;
            end
            START: begin
                if (baud_q == '0) begin
                    state_d   = DATA;
                    baud_d    = div_lat_q - DIV_W'(1);
                    bit_cnt_d = 3'd0;
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end
            DATA: begin
                if (baud_q == '0) begin
                    baud_d = div_lat_q - DIV_W'(1);
                    if (bit_cnt_q == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end
`ifdef MMIO_UART_PARITY_EN
            PARITY: begin
                if (baud_q == '0) begin
                    state_d = STOP;
                    baud_d  = div_lat_q - DIV_W'(1);
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end
`endif
            STOP: begin
                if (baud_q == '0) begin
                    load = !fifo_empty;
                    if (fifo_empty) begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        fifo_pop = load;
        if (load) begin
            state_d   = START;
            shift_d   = fifo_rdata;
            div_lat_d = divisor_q;
            baud_d    = divisor_q - DIV_W'(1);
`ifdef MMIO_UART_PARITY_EN
            parity_d  = even_parity(fifo_rdata);
`endif
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef MMIO_UART_PARITY_EN
            PARITY:  tx_d = parity_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_valid_q <= 1'b0;
            pending_byte_q  <= '0;
            wc_q            <= 1'b0;
            divisor_q       <= DIV_W'(DEFAULT_DIVISOR);
            state_q         <= IDLE;
            baud_q          <= '0;
            div_lat_q       <= DIV_W'(DEFAULT_DIVISOR);
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            tx_q            <= 1'b1;
`ifdef MMIO_UART_PARITY_EN
            parity_q        <= 1'b0;
`endif
        end else begin
            pending_valid_q <= pending_valid_d;
            pending_byte_q  <= pending_byte_d;
            wc_q            <= wc_d;
            divisor_q       <= divisor_d;
            state_q         <= state_d;
            baud_q          <= baud_d;
            div_lat_q       <= div_lat_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            tx_q            <= tx_d;
`ifdef MMIO_UART_PARITY_EN
            parity_q        <= parity_d;
`endif
        end
    end

    assign uart_tx                         = tx_q;
    assign memory_mapped_io_write_complete = wc_q;

    always_comb begin
        memory_mapped_io_r_data                    = '0;
        memory_mapped_io_r_data[STATUS_TX_BUSY]    = (state_q != IDLE);
        memory_mapped_io_r_data[STATUS_FIFO_FULL]  = fifo_full;
        memory_mapped_io_r_data[STATUS_FIFO_EMPTY] = fifo_empty;
        memory_mapped_io_r_data[STATUS_PENDING]    = pending_valid_q;
        memory_mapped_io_r_data[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(fifo_count);
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with DEFAULT_DIVISOR=4 and FIFO_DEPTH=4.
module tb_mmio_uart_tx;
    import mmio_uart_tx_pkg::*;

    localparam logic [31:0] BASE = 32'h0003_0000;
`ifdef MMIO_UART_PARITY_EN
    localparam int FRAME = 45;
    localparam logic [44:0] EXP_55 = 45'h1_F00F0F0F0F0;
`else
    localparam int FRAME = 41;
    localparam logic [44:0] EXP_55 = 45'h0_01F0F0F0F0F0;
`endif

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    mem_write_control_t ctrl;
    logic [31:0]        r_data;
    logic               wc;
    logic               uart_tx;
    int                 checks = 0;
    int                 errors = 0;

    mmio_uart_tx #(
        .MMIO_BASE       (BASE),
        .FIFO_DEPTH      (4),
        .DEFAULT_DIVISOR (4)
    ) dut (
        .clock                           (clock),
        .reset                           (reset),
        .memory_mapped_io_control        (ctrl),
        .memory_mapped_io_r_data         (r_data),
        .memory_mapped_io_write_complete (wc),
        .uart_tx                         (uart_tx)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic store(input logic [31:0] addr, input logic [31:0] val);
        @(posedge clock); #1;
        ctrl.enable = 1'b1;
        ctrl.addr   = addr;
        ctrl.value  = val;
        ctrl.width  = 2'd2;
        @(posedge clock); #1;
        ctrl.enable = 1'b0;
    endtask

    // Receives one frame, checking every cycle of each bit holds its level.
    task automatic rx_byte(input int div, output logic [7:0] b, output logic p,
                           output logic ok, output int waited);
        ok = 1'b1; b = '0; p = 1'b0; waited = 0;
        do begin
            @(posedge clock); #1;
            waited++;
        end while (uart_tx !== 1'b0 && waited < 400);
        if (uart_tx !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        for (int i = 1; i < div; i++) begin
            @(posedge clock); #1;
            if (uart_tx !== 1'b0) ok = 1'b0;
        end
        for (int k = 0; k < 8; k++) begin
            @(posedge clock); #1;
            b[k] = uart_tx;
            for (int i = 1; i < div; i++) begin
                @(posedge clock); #1;
                if (uart_tx !== b[k]) ok = 1'b0;
            end
        end
`ifdef MMIO_UART_PARITY_EN
        @(posedge clock); #1;
        p = uart_tx;
        for (int i = 1; i < div; i++) begin
            @(posedge clock); #1;
            if (uart_tx !== p) ok = 1'b0;
        end
`endif
        for (int i = 0; i < div; i++) begin
            @(posedge clock); #1;
            if (uart_tx !== 1'b1) ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        int pulses;
        ctrl = '0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_uart_tx got=%b exp=1", uart_tx); end
        checks++; if (r_data !== 32'h0000_0004) begin errors++; $display("FAIL reset_status got=%h exp=00000004", r_data); end
        pulses = 0;
        repeat (20) begin
            @(posedge clock); #1;
            if (wc !== 1'b0) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL reset_no_wc got=%0d pulses exp=0", pulses); end
    endtask

    task automatic test_other_offset();
        int bad;
        store(BASE + 32'h8, 32'h12);
        checks++; if (wc !== 1'b1) begin errors++; $display("FAIL other_offset_wc got=%b exp=1", wc); end
        store(BASE - 32'h4, 32'h34);
        checks++; if (wc !== 1'b1) begin errors++; $display("FAIL out_of_window_wc got=%b exp=1", wc); end
        @(posedge clock); #1;
        checks++; if (wc !== 1'b0) begin errors++; $display("FAIL other_offset_wc_len got=%b exp=0", wc); end
        bad = 0;
        repeat (60) begin
            @(posedge clock); #1;
            if (uart_tx !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL other_offset_line got=%0d low cycles exp=0", bad); end
        checks++; if (r_data !== 32'h0000_0004) begin errors++; $display("FAIL other_offset_status got=%h exp=00000004", r_data); end
    endtask

    task automatic test_single_byte();
        logic [44:0] got;
        logic        busy;
        got = '0;
        busy = 1'b0;
        store(BASE, 32'h55);
        checks++; if (wc !== 1'b1) begin errors++; $display("FAIL single_wc got=%b exp=1", wc); end
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL single_pre_start got=%b exp=1", uart_tx); end
        for (int i = 0; i < FRAME; i++) begin
            @(posedge clock); #1;
            got[i] = uart_tx;
            if (i == 0) begin
                checks++; if (wc !== 1'b0) begin errors++; $display("FAIL single_wc_len got=%b exp=0", wc); end
            end
            if (i == 5) busy = r_data[0];
        end
        checks++; if (got !== EXP_55) begin errors++; $display("FAIL single_frame got=%h exp=%h", got, EXP_55); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    endtask

    task automatic test_fifo_full();
        fork
            begin
                logic prev;
                logic done;
                int   n;
                int   pend_drop;
                for (int k = 1; k <= 5; k++) begin
                    store(BASE, 32'(k));
                    checks++; if (wc !== 1'b1) begin errors++; $display("FAIL full_wc_%0d got=%b exp=1", k, wc); end
                end
                store(BASE, 32'h06);
                checks++; if (wc !== 1'b0) begin errors++; $display("FAIL full_wc_withheld got=%b exp=0", wc); end
                checks++; if (r_data !== 32'h0000_040B) begin errors++; $display("FAIL full_status got=%h exp=0000040b", r_data); end
                prev = uart_tx; done = 1'b0; n = 0; pend_drop = 0;
                while (!done && n < 200) begin
                    @(posedge clock); #1;
                    n++;
                    if (wc === 1'b1) done = 1'b1;
                    else begin
                        if (r_data[3] !== 1'b1) pend_drop++;
                        prev = uart_tx;
                    end
                end
                checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_wc_timeout got=%b exp=1", done); end
                checks++; if (pend_drop != 0) begin errors++; $display("FAIL full_pending_bit got=%0d drops exp=0", pend_drop); end
                checks++; if ({prev, uart_tx} !== 2'b10) begin errors++; $display("FAIL full_wc_at_pop got=%b exp=10", {prev, uart_tx}); end
                checks++; if (r_data !== 32'h0000_0403) begin errors++; $display("FAIL full_status_after got=%h exp=00000403", r_data); end
            end
            begin
                logic [7:0] b;
                logic       p, ok;
                int         waited;
                for (int k = 1; k <= 6; k++) begin
                    rx_byte(4, b, p, ok, waited);
                    checks++; if (b !== 8'(k) || ok !== 1'b1) begin errors++; $display("FAIL full_rx_%0d got=%h ok=%b exp=%h ok=1", k, b, ok, 8'(k)); end
                    if (k > 1) begin
                        checks++; if (waited != 1) begin errors++; $display("FAIL full_b2b_%0d got=%0d exp=1", k, waited); end
                    end
                end
            end
        join
    endtask

    task automatic test_divisor();
        store(BASE + 32'h4, 32'h0);
        checks++; if (wc !== 1'b1) begin errors++; $display("FAIL div_wc got=%b exp=1", wc); end
        fork
            begin
                store(BASE, 32'hFF);
                store(BASE, 32'h3C);
                store(BASE + 32'h4, 32'h8);
            end
            begin
                logic [7:0] b;
                logic       p, ok;
                int         waited;
                rx_byte(1, b, p, ok, waited);
                checks++; if (b !== 8'hFF || ok !== 1'b1) begin errors++; $display("FAIL div1_rx got=%h ok=%b exp=ff ok=1", b, ok); end
                rx_byte(8, b, p, ok, waited);
                checks++; if (b !== 8'h3C || ok !== 1'b1) begin errors++; $display("FAIL div8_rx got=%h ok=%b exp=3c ok=1", b, ok); end
                checks++; if (waited != 1) begin errors++; $display("FAIL div_b2b got=%0d exp=1", waited); end
            end
        join
    endtask

    task automatic test_reset_midframe();
        int bad;
        store(BASE, 32'hA5);
        checks++; if (wc !== 1'b1) begin errors++; $display("FAIL mid_wc got=%b exp=1", wc); end
        repeat (19) begin
            @(posedge clock); #1;
        end
        checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL mid_bit1 got=%b exp=0", uart_tx); end
        reset = 1'b1;
        #1;
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL mid_async_tx got=%b exp=1", uart_tx); end
        checks++; if (r_data !== 32'h0000_0004) begin errors++; $display("FAIL mid_status got=%h exp=00000004", r_data); end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        bad = 0;
        repeat (100) begin
            @(posedge clock); #1;
            if (uart_tx !== 1'b1 || wc !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL mid_quiet got=%0d bad cycles exp=0", bad); end
    endtask

`ifdef MMIO_UART_PARITY_EN
    task automatic test_parity();
        logic [7:0] b;
        logic       p, ok;
        int         waited;
        store(BASE, 32'h07);
        checks++; if (wc !== 1'b1) begin errors++; $display("FAIL par07_wc got=%b exp=1", wc); end
        rx_byte(4, b, p, ok, waited);
        checks++; if (b !== 8'h07 || p !== 1'b1 || ok !== 1'b1) begin errors++; $display("FAIL par07 got=%h p=%b ok=%b exp=07 p=1 ok=1", b, p, ok); end
        store(BASE, 32'h03);
        rx_byte(4, b, p, ok, waited);
        checks++; if (b !== 8'h03 || p !== 1'b0 || ok !== 1'b1) begin errors++; $display("FAIL par03 got=%h p=%b ok=%b exp=03 p=0 ok=1", b, p, ok); end
    endtask
`endif

    initial begin
        test_reset();
        test_other_offset();
        test_single_byte();
        test_fifo_full();
        test_divisor();
        test_reset_midframe();
`ifdef MMIO_UART_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
